// File: rtl/sfp_dis_filter.sv
// sfp_dis_filter: synchronises and debounces the 8 descrambled backplane SFP
// disable lines, keeps sticky per-line change flags with a maskable level IRQ,
// selects the own-slot line as the SFP TX_DISABLE and counts own-slot
// disable assertions in a saturating counter.
// Optional build macro SFP_DIS_FORCE_EN adds force_en/force_val override ports.
module sfp_dis_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SFP_DIS_FORCE_EN
  input  logic             force_en,
  input  logic             force_val,
`endif
  input  logic [7:0]       sfp_dis_lines,
  input  logic [2:0]       bp_slot_addr,
  input  logic [7:0]       irq_mask,
  input  logic [7:0]       flag_clr,
  input  logic             cnt_clr,
  output logic [7:0]       filt_lines,
  output logic [7:0]       chg_flags,
  output logic             irq,
  output logic             sfp_dis_out,
  output logic [CNT_W-1:0] assert_cnt
);

  localparam int unsigned NLINES = 8;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [7:0]       r_s1;
  logic [7:0]       r_s2;
  logic [7:0]       r_filt;
  logic [DB_W-1:0]  r_db_cnt [NLINES];
  logic [7:0]       r_chg;
  logic             r_irq;
  logic             r_sfp_dis;
  logic             r_own_prev;
  logic [CNT_W-1:0] r_assert_cnt;

  logic [7:0]       w_filt_nxt;
  logic [DB_W-1:0]  w_db_nxt [NLINES];
  logic [7:0]       w_chg_nxt;
  logic             w_own;
  logic             w_own_rise;
  logic             w_sfp_nxt;

  // Per-line debounce: a differing level must persist DEBOUNCE_CYCLES samples
  always_comb begin
    w_filt_nxt = r_filt;
    for (int i = 0; i < int'(NLINES); i++) begin
      w_db_nxt[i] = '0;
      if (r_s2[i] != r_filt[i]) begin
        if (r_db_cnt[i] == DB_LAST) begin
          w_filt_nxt[i] = r_s2[i];
        end else begin
          w_db_nxt[i] = r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Flag update (set beats clear), own-slot selection and output override
  always_comb begin
    w_chg_nxt  = (r_chg & ~flag_clr) | (w_filt_nxt ^ r_filt);
    w_own      = r_filt[bp_slot_addr];
    w_own_rise = w_own & ~r_own_prev;
`ifdef SFP_DIS_FORCE_EN
    w_sfp_nxt  = force_en ? force_val : w_own;
`else
    w_sfp_nxt  = w_own;
`endif
  end

  // Two-flop synchroniser, reset to the safe "disabled" level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 8'hFF;
      r_s2 <= 8'hFF;
    end else begin
      r_s1 <= sfp_dis_lines;
      r_s2 <= r_s1;
    end
  end

  // Filtered levels and debounce counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 8'hFF;
      for (int i = 0; i < int'(NLINES); i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_filt <= w_filt_nxt;
      for (int i = 0; i < int'(NLINES); i++) begin
        r_db_cnt[i] <= w_db_nxt[i];
      end
    end
  end

  // Sticky change flags and level IRQ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chg <= '0;
      r_irq <= 1'b0;
    end else begin
      r_chg <= w_chg_nxt;
      r_irq <= |(r_chg & irq_mask);
    end
  end

  // Own-slot TX_DISABLE output and saturating assertion counter (clear wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sfp_dis    <= 1'b1;
      r_own_prev   <= 1'b1;
      r_assert_cnt <= '0;
    end else begin
      r_sfp_dis  <= w_sfp_nxt;
      r_own_prev <= w_own;
      if (cnt_clr) begin
        r_assert_cnt <= '0;
      end else if (w_own_rise && (r_assert_cnt != CNT_MAX)) begin
        r_assert_cnt <= r_assert_cnt + CNT_W'(1);
      end
    end
  end

  assign filt_lines  = r_filt;
  assign chg_flags   = r_chg;
  assign irq         = r_irq;
  assign sfp_dis_out = r_sfp_dis;
  assign assert_cnt  = r_assert_cnt;

endmodule

// File: tb/tb_sfp_dis_filter.sv
// Self-checking bench for sfp_dis_filter (DEBOUNCE_CYCLES=4, CNT_W=8, default build).
module tb_sfp_dis_filter;

  localparam int unsigned NV = 10;

  logic       clk;
  logic       rst_n;
  logic [7:0] sfp_dis_lines;
  logic [2:0] bp_slot_addr;
  logic [7:0] irq_mask;
  logic [7:0] flag_clr;
  logic       cnt_clr;
  logic [7:0] filt_lines;
  logic [7:0] chg_flags;
  logic       irq;
  logic       sfp_dis_out;
  logic [7:0] assert_cnt;

  int n_total;
  int n_bad;

  typedef struct {
    logic [7:0] lines;
    logic [2:0] slot;
    logic [7:0] mask;
    logic [7:0] clr;
    logic [7:0] e_filt;
    logic [7:0] e_chg;
    logic       e_irq;
    logic       e_sfp;
    logic [7:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [7:0] filt;
    logic [7:0] chg;
    logic       irq;
    logic       sfp;
    logic [7:0] cnt;
  } exp_t;

  vec_t vt [NV];
  exp_t sb_q [$];

  sfp_dis_filter #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sfp_dis_lines (sfp_dis_lines),
    .bp_slot_addr  (bp_slot_addr),
    .irq_mask      (irq_mask),
    .flag_clr      (flag_clr),
    .cnt_clr       (cnt_clr),
    .filt_lines    (filt_lines),
    .chg_flags     (chg_flags),
    .irq           (irq),
    .sfp_dis_out   (sfp_dis_out),
    .assert_cnt    (assert_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Advance n clock edges, then settle 1 time unit past the last edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [7:0] f, input logic [7:0] c, input logic i,
                         input logic s, input logic [7:0] n);
    exp_t e;
    e.filt = f; e.chg = c; e.irq = i; e.sfp = s; e.cnt = n;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string nm);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL %s: scoreboard empty got 0 entries want 1", nm);
    end else begin
      e = sb_q.pop_front();
      chk({nm, "_filt"}, 32'(filt_lines),  32'(e.filt));
      chk({nm, "_chg"},  32'(chg_flags),   32'(e.chg));
      chk({nm, "_irq"},  32'(irq),         32'(e.irq));
      chk({nm, "_sfp"},  32'(sfp_dis_out), 32'(e.sfp));
      chk({nm, "_cnt"},  32'(assert_cnt),  32'(e.cnt));
    end
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    rst_n         = 1'b0;
    sfp_dis_lines = 8'hFF;
    bp_slot_addr  = 3'd3;
    irq_mask      = 8'h08;
    flag_clr      = 8'h00;
    cnt_clr       = 1'b0;

    // Steady-state vectors, each starting from the state the previous one left
    vt[0] = '{8'h0F, 3'd3, 8'h00, 8'h00, 8'h0F, 8'hF0, 1'b0, 1'b1, 8'd1};
    vt[1] = '{8'h0F, 3'd5, 8'h20, 8'h00, 8'h0F, 8'hF0, 1'b1, 1'b0, 8'd1};
    vt[2] = '{8'h0F, 3'd2, 8'h20, 8'hFF, 8'h0F, 8'h00, 1'b0, 1'b1, 8'd2};
    vt[3] = '{8'h0B, 3'd2, 8'h04, 8'h00, 8'h0B, 8'h04, 1'b1, 1'b0, 8'd2};
    vt[4] = '{8'h0F, 3'd2, 8'h04, 8'h00, 8'h0F, 8'h04, 1'b1, 1'b1, 8'd3};
    vt[5] = '{8'hA5, 3'd0, 8'h0F, 8'h04, 8'hA5, 8'hAA, 1'b1, 1'b1, 8'd3};
    vt[6] = '{8'hA5, 3'd0, 8'h50, 8'hAA, 8'hA5, 8'h00, 1'b0, 1'b1, 8'd3};
    vt[7] = '{8'h5A, 3'd0, 8'h01, 8'h00, 8'h5A, 8'hFF, 1'b1, 1'b0, 8'd3};
    vt[8] = '{8'h5A, 3'd1, 8'h00, 8'hFF, 8'h5A, 8'h00, 1'b0, 1'b1, 8'd4};
    vt[9] = '{8'hFF, 3'd7, 8'hFF, 8'h00, 8'hFF, 8'hA5, 1'b1, 1'b1, 8'd5};

    // Reset values while held in reset
    tick(2);
    sb_push(8'hFF, 8'h00, 1'b0, 1'b1, 8'h00);
    sb_check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Glitch: line 3 low for only 3 samples is rejected
    sfp_dis_lines = 8'hF7;
    tick(3);
    sfp_dis_lines = 8'hFF;
    tick(10);
    sb_push(8'hFF, 8'h00, 1'b0, 1'b1, 8'h00);
    sb_check("glitch");

    // Step: exact latency of filt/flag (edge 6) and sfp_dis_out/irq (edge 7)
    sfp_dis_lines = 8'hF7;
    tick(5);
    chk("step_e5_filt", 32'(filt_lines), 32'h00FF);
    tick(1);
    chk("step_e6_filt", 32'(filt_lines), 32'h00F7);
    chk("step_e6_chg",  32'(chg_flags),  32'h0008);
    chk("step_e6_sfp",  32'(sfp_dis_out), 32'h1);
    chk("step_e6_irq",  32'(irq),        32'h0);
    tick(1);
    chk("step_e7_sfp",  32'(sfp_dis_out), 32'h0);
    chk("step_e7_irq",  32'(irq),        32'h1);

    // Collision: clear on the edge line 3 changes again -> set wins
    sfp_dis_lines = 8'hFF;
    tick(5);
    flag_clr = 8'h08;
    tick(1);
    flag_clr = 8'h00;
    chk("coll_filt", 32'(filt_lines), 32'h00FF);
    chk("coll_chg",  32'(chg_flags),  32'h0008);
    flag_clr = 8'h08;
    tick(1);
    flag_clr = 8'h00;
    chk("lone_clr_chg", 32'(chg_flags), 32'h0000);
    chk("lone_clr_irq_still", 32'(irq), 32'h1);
    tick(1);
    chk("lone_clr_irq", 32'(irq), 32'h0);
    chk("coll_cnt", 32'(assert_cnt), 32'h1);

    // Table-driven steady-state vectors
    for (int i = 0; i < int'(NV); i++) begin
      sfp_dis_lines = vt[i].lines;
      bp_slot_addr  = vt[i].slot;
      irq_mask      = vt[i].mask;
      flag_clr      = vt[i].clr;
      sb_push(vt[i].e_filt, vt[i].e_chg, vt[i].e_irq, vt[i].e_sfp, vt[i].e_cnt);
      tick(1);
      flag_clr = 8'h00;
      tick(11);
      sb_check($sformatf("vec%0d", i));
    end

    // Counter: 260 own-slot assertions from count 5 saturate at FF
    irq_mask = 8'h00;
    sb_push(8'hFF, 8'hA5, 1'b0, 1'b1, 8'hFF);
    for (int k = 0; k < 260; k++) begin
      sfp_dis_lines = 8'h7F;
      tick(7);
      sfp_dis_lines = 8'hFF;
      tick(7);
      if (k == 2) chk("cnt_mid", 32'(assert_cnt), 32'd8);
    end
    sb_check("cnt_sat");

    // Slot change alone moves the output the next edge
    sfp_dis_lines = 8'hF7;
    bp_slot_addr  = 3'd3;
    tick(12);
    chk("slot3_sfp", 32'(sfp_dis_out), 32'h0);
    bp_slot_addr = 3'd4;
    tick(1);
    chk("slot4_sfp", 32'(sfp_dis_out), 32'h1);
    chk("slot4_filt", 32'(filt_lines), 32'h00F7);

    // cnt_clr, then clear coinciding with an increment -> 0
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("cnt_clr", 32'(assert_cnt), 32'h0);
    sfp_dis_lines = 8'hE7;
    tick(12);
    sfp_dis_lines = 8'hF7;
    tick(5);
    cnt_clr = 1'b1;
    tick(2);
    cnt_clr = 1'b0;
    tick(4);
    chk("cnt_clr_wins", 32'(assert_cnt), 32'h0);
    sfp_dis_lines = 8'hE7;
    tick(12);
    sfp_dis_lines = 8'hF7;
    tick(12);
    chk("cnt_after_clr", 32'(assert_cnt), 32'h1);

    // Reset mid-debounce: outputs return to reset values at once
    sfp_dis_lines = 8'h00;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    sb_push(8'hFF, 8'h00, 1'b0, 1'b1, 8'h00);
    sb_check("mid_rst");
    sfp_dis_lines = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
    tick(10);
    chk("post_rst_filt", 32'(filt_lines), 32'h00FF);
    chk("post_rst_chg",  32'(chg_flags),  32'h0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
